// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the iterative HI/LO multiply/divide sequencer:
// ALU op codes, FSM state type and op-classification helpers.
package muldiv_sequencer_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;

    localparam logic [4:0] ALU_DIV   = 5'd3;
    localparam logic [4:0] ALU_DIVU  = 5'd4;
    localparam logic [4:0] ALU_MULT  = 5'd11;
    localparam logic [4:0] ALU_MULTU = 5'd12;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_e;

    function automatic logic is_legal_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU) ||
               (op == ALU_MULT) || (op == ALU_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [4:0] op);
        return (op == ALU_DIV) || (op == ALU_MULT);
    endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Multi-cycle HI/LO unit: WIDTH shift-add / restoring shift-subtract steps on
// operand magnitudes, then a sign-fix cycle that writes HI/LO and pulses done.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi_en,
    input  logic             mtlo_en,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opr_q, opr_d;
    logic [4:0]           op_q, op_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 sgn_op;
    logic                 accept;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_top;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix, rem_fix;

    always_comb begin
        sgn_op = is_signed_op(op);
        accept = start && is_legal_op(op) && (state_q == IDLE);
        mag_a  = (sgn_op && a[WIDTH-1]) ? -a : a;
        mag_b  = (sgn_op && b[WIDTH-1]) ? -b : b;

        // acc = {partial product, remaining multiplier}; shifts right each step
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opr_q};

        // acc = {remainder, remaining dividend}; top is the left-shifted remainder,
        // one bit wider so the trial subtract's borrow is exact
        div_top  = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff = div_top - {1'b0, opr_q};

        prod_fix = neg_res_q ? -acc_q : acc_q;
        quot_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opr_d     = opr_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = CALC;
                    cnt_d     = '0;
                    op_d      = op;
                    acc_d     = {{WIDTH{1'b0}}, mag_a};
                    opr_d     = mag_b;
                    neg_res_d = sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = sgn_op && a[WIDTH-1];
                end else begin
                    if (mthi_en) hi_d = wdata;
                    if (mtlo_en) lo_d = wdata;
                end
            end
            CALC: begin
                if (is_div_op(op_q)) begin
                    if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else                  acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                end else begin
                    if (acc_q[0]) acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    else          acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) state_d = FIX;
            end
            FIX: begin
                if (is_div_op(op_q)) begin
                    hi_d = rem_fix;
                    lo_d = quot_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opr_q     <= '0;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opr_q     <= opr_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter: WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin the operation given by op.
REQ-005 op  input  5  ALU control code: 3 DIV, 4 DIVU, 11 MULT, 12 MULTU.
REQ-006 a  input  WIDTH  multiplicand / dividend (rs).
REQ-007 b  input  WIDTH  multiplier / divisor (rt).
REQ-008 mthi_en  input  1  write wdata into HI (MTHI).
REQ-009 mtlo_en  input  1  write wdata into LO (MTLO).
REQ-010 wdata  input  WIDTH  data for MTHI/MTLO.
REQ-011 busy  output  1  operation in progress; core stalls MFHI/MFLO/MTHI/MTLO and new mult/div while high.
REQ-012 done  output  1  one-cycle pulse; HI/LO hold the new result.
REQ-013 hi  output  WIDTH  HI register.
REQ-014 lo  output  WIDTH  LO register.

Function
REQ-015 FSM states: IDLE, CALC, FIX; DONE is a registered flag, not a state.
REQ-016 In IDLE, start=1 with a legal op captures a, b, op at edge E0 and enters CALC; busy=1 from E0.
REQ-017 start with an op other than 3/4/11/12 is ignored; state, HI, LO unchanged.
REQ-018 start while busy=1 is ignored; operands are not recaptured.
REQ-019 CALC performs one shift-add (multiply) or restoring shift-subtract (divide) step per cycle on operand magnitudes, for exactly WIDTH edges (E1..E32); a 6-bit counter tracks steps.
REQ-020 FIX (edge E33) applies signs, writes HI/LO, returns to IDLE; busy=0 and done=1 for exactly the cycle after E33; start-to-done latency 33 cycles.
REQ-021 MULTU: {hi,lo} = a*b, 64-bit unsigned.
REQ-022 MULT: {hi,lo} = signed 64-bit product; magnitude product negated when sign(a) != sign(b).
REQ-023 DIVU: lo = a/b, hi = a%b, unsigned.
REQ-024 DIV: quotient truncates toward zero (negated if signs differ); remainder takes dividend sign.
REQ-025 Divide by zero is not trapped: DIVU gives lo=0xFFFFFFFF, hi=a; DIV gives hi=a, lo=0xFFFFFFFF if a>=0, else 0x00000001.
REQ-026 DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
REQ-027 MTHI/MTLO in IDLE update HI/LO at the next edge; both may assert in the same cycle.
REQ-028 MTHI/MTLO while busy=1 are dropped.
REQ-029 start (legal) and MTHI/MTLO in the same IDLE cycle: start accepted, move dropped.
REQ-030 A new start may be accepted in the cycle done=1 (back-to-back, no bubble).
REQ-031 HI/LO keep their previous values throughout CALC and FIX until the E33 write.

Reset
REQ-032 rst_n=0 asynchronously forces IDLE, busy=0, done=0, hi=0, lo=0, step counter=0, internal accumulators=0.
REQ-033 Reset mid-operation abandons it; no done pulse follows and HI/LO read 0.
REQ-034 After rst_n rises, start is accepted on the first clock edge.

Structure
REQ-035 Shared package holds op code constants (ALU_DIV=3, ALU_DIVU=4, ALU_MULT=11, ALU_MULTU=12), the FSM state enum, and WIDTH default.
REQ-036 Single module with no sub-module; step datapath (64-bit accumulator, WIDTH-bit operand register, sign flags) is inline.

Verification
REQ-037 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done at cycle 33, hi=0xFFFFFFFE, lo=0x00000001.
REQ-038 MULT a=-7 (0xFFFFFFF9), b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-039 DIVU a=100, b=0 -> hi=100, lo=0xFFFFFFFF; DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
REQ-040 MTHI wdata=0x1234 in IDLE, then start MULT mid-run with mthi_en=1 -> first write lands, mid-run write dropped, second start ignored, HI/LO = product.
REQ-041 rst_n pulsed low at cycle 10 of DIVU -> busy=0, hi=lo=0 immediately, no done pulse.
REQ-042 start MULTU 2*3, then start DIVU 7/2 in the done cycle -> lo=6 then lo=3, hi=1, consecutive done pulses 33 cycles apart.
